mmu_req_arbiter: RTL and testbench
==================================

MMU_REQ_ARBITER -- requirements
Module: mmu_req_arbiter

Interface
REQ-001 SHALL have parameter ST_LIMIT, default 4: number of consecutive I-side losses before I-side is forced to win.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum BUSY cycles to wait for m_ack.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request.
- i_addr  in  32  fetch address.
- i_trd  in  3  fetch thread id.
- i_gnt  out  1  fetch request accepted.
- i_valid  out  1  fetch response.
- i_rd_data  out  32  fetch data.
- i_miss  out  1  fetch miss.
- i_segfault  out  1  fetch fault.
- d_rd  in  1  data read request.
- d_wr  in  1  data write request.
- d_addr  in  32  data address.
- d_wr_data  in  32  write data.
- d_trd  in  3  data thread id.
- d_gnt  out  1  data request accepted.
- d_valid  out  1  data response.
- d_rd_data  out  32  read data.
- d_miss  out  1  data miss.
- d_segfault  out  1  data fault.
- m_opcode  out  2  memory opcode: IDLE=2'b00, READ=2'b01, WRITE=2'b11.
- m_addr  out  32  memory address.
- m_wr_data  out  32  memory write data.
- m_trd  out  3  memory thread id.
- m_ack  in  1  operation complete.
- m_rd_data  in  32  memory read data.
- m_miss  in  1  memory miss.
- m_segfault  in  1  memory fault.

Function
REQ-005 SHALL implement the FSM IDLE -> BUSY -> RESP -> IDLE, plus IDLE -> RESP for a rejected request.
REQ-006 In IDLE, SHALL assert exactly one of i_gnt/d_gnt combinationally in any cycle with a pending request; the grant is a one-cycle pulse, and the requester holds its inputs stable until granted.
REQ-007 Arbitration: the D side (d_rd|d_wr) SHALL win over i_req, unless the starvation counter equals ST_LIMIT, in which case I SHALL win.
REQ-008 Starvation counter SHALL increment on each IDLE cycle in which i_req loses to D, clear when I is granted, and saturate at ST_LIMIT.
REQ-009 On grant, SHALL latch address, write data, thread id, opcode and source (I/D), and go to BUSY on the next edge.
REQ-010 In BUSY, SHALL drive m_opcode/m_addr/m_wr_data/m_trd from the latched request; I fetch SHALL use READ, d_rd READ, d_wr WRITE; m_opcode SHALL be IDLE in all other states.
REQ-011 On the BUSY cycle with m_ack=1, SHALL capture m_rd_data/m_miss/m_segfault and go to RESP.
REQ-012 In RESP, SHALL pulse the source's x_valid for exactly one cycle with the captured data/flags, then return to IDLE; no grant SHALL occur in RESP.
REQ-013 Minimum latency SHALL be: grant in cycle 0, m_opcode valid in cycle 1, m_ack no earlier than cycle 1, x_valid in cycle m_ack+1.
REQ-014 For a write, x_rd_data SHALL be 0 in the response.
REQ-015 The BUSY cycle counter SHALL reset on entry to BUSY; if it reaches TIMEOUT without m_ack, SHALL go to RESP with segfault=1, miss=0, data=0.
REQ-016 m_ack outside BUSY SHALL be ignored.
REQ-017 d_rd=1 and d_wr=1 together SHALL be granted, issue no memory operation, and produce d_valid on the next cycle with d_segfault=1 and data 0.
REQ-018 Response outputs (x_rd_data/x_miss/x_segfault) SHALL be 0 whenever x_valid=0.
REQ-019 Requests arriving while BUSY or RESP SHALL wait, and SHALL not be dropped while held.

Reset
REQ-020 rst_n low SHALL asynchronously force: state IDLE; m_opcode 2'b00; m_addr/m_wr_data 0; m_trd 0; all gnt/valid/data/flag outputs 0; starvation counter 0; timeout counter 0.
REQ-021 Reset mid-BUSY SHALL abort the operation with no x_valid pulse; the first grant is allowed on the first cycle with rst_n high.

Verification
REQ-022 Bench SHALL cover: i_req, addr 0x100, trd 3, m_ack in cycle 2 with data 0xDEADBEEF -> i_gnt in cycle 0, m_opcode=01 in cycles 1-2, i_valid in cycle 3 with 0xDEADBEEF.
REQ-023 Bench SHALL cover: d_wr and i_req held continuously, m_ack immediate -> D granted 4 times, then I granted, and the counter clears.
REQ-024 Bench SHALL cover: d_rd, m_ack never asserted, TIMEOUT=8 -> d_valid with d_segfault=1 eight BUSY cycles after grant.
REQ-025 Bench SHALL cover: d_rd=d_wr=1 -> d_gnt, m_opcode remains 00, d_valid with segfault=1 the next cycle.
REQ-026 Bench SHALL cover: rst_n low in BUSY -> m_opcode 00 immediately, no valid pulse; a request after reset is serviced normally.

Source files
------------

// File: rtl/mmu_req_arbiter.sv
// Arbitrates I-fetch and D-side requests onto one memory port (IDLE -> BUSY -> RESP).
// Grant is combinational in IDLE, response is one cycle after m_ack, and a BUSY timeout forces a segfault.
module mmu_req_arbiter #(
    parameter int ST_LIMIT = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_trd,
    output logic        i_gnt,
    output logic        i_valid,
    output logic [31:0] i_rd_data,
    output logic        i_miss,
    output logic        i_segfault,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wr_data,
    input  logic [2:0]  d_trd,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rd_data,
    output logic        d_miss,
    output logic        d_segfault,
    output logic [1:0]  m_opcode,
    output logic [31:0] m_addr,
    output logic [31:0] m_wr_data,
    output logic [2:0]  m_trd,
    input  logic        m_ack,
    input  logic [31:0] m_rd_data,
    input  logic        m_miss,
    input  logic        m_segfault
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b11;

    localparam int SW = (ST_LIMIT < 1) ? 1 : $clog2(ST_LIMIT + 1);
    localparam int TW = (TIMEOUT  < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] ST_MAX  = SW'(ST_LIMIT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_t        state_q;
    logic [SW-1:0] st_cnt_q;
    logic [TW-1:0] to_cnt_q;
    logic [1:0]    op_q;
    logic [31:0]   addr_q;
    logic [31:0]   wr_data_q;
    logic [2:0]    trd_q;
    logic          src_i_q;
    logic [31:0]   rsp_data_q;
    logic          rsp_miss_q;
    logic          rsp_seg_q;

    logic d_req;
    logic grant_i;
    logic grant_d;

    // I wins only when D is idle or I has been starved for ST_LIMIT arbitrations
    assign d_req   = d_rd | d_wr;
    assign grant_i = (state_q == S_IDLE) && i_req && (!d_req || (st_cnt_q == ST_MAX));
    assign grant_d = (state_q == S_IDLE) && d_req && !grant_i;

    assign i_gnt = grant_i;
    assign d_gnt = grant_d;

    assign m_opcode  = (state_q == S_BUSY) ? op_q : OP_IDLE;
    assign m_addr    = addr_q;
    assign m_wr_data = wr_data_q;
    assign m_trd     = trd_q;

    assign i_valid    = (state_q == S_RESP) &&  src_i_q;
    assign d_valid    = (state_q == S_RESP) && !src_i_q;
    assign i_rd_data  = i_valid ? rsp_data_q : 32'd0;
    assign i_miss     = i_valid & rsp_miss_q;
    assign i_segfault = i_valid & rsp_seg_q;
    assign d_rd_data  = d_valid ? rsp_data_q : 32'd0;
    assign d_miss     = d_valid & rsp_miss_q;
    assign d_segfault = d_valid & rsp_seg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            st_cnt_q   <= '0;
            to_cnt_q   <= '0;
            op_q       <= OP_IDLE;
            addr_q     <= 32'd0;
            wr_data_q  <= 32'd0;
            trd_q      <= 3'd0;
            src_i_q    <= 1'b0;
            rsp_data_q <= 32'd0;
            rsp_miss_q <= 1'b0;
            rsp_seg_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_i) begin
                        st_cnt_q  <= '0;
                        to_cnt_q  <= '0;
                        op_q      <= OP_READ;
                        addr_q    <= i_addr;
                        wr_data_q <= 32'd0;
                        trd_q     <= i_trd;
                        src_i_q   <= 1'b1;
                        state_q   <= S_BUSY;
                    end else if (grant_d) begin
                        if (i_req && (st_cnt_q != ST_MAX)) begin
                            st_cnt_q <= st_cnt_q + SW'(1);
                        end
                        to_cnt_q  <= '0;
                        addr_q    <= d_addr;
                        wr_data_q <= d_wr_data;
                        trd_q     <= d_trd;
                        src_i_q   <= 1'b0;
                        // Simultaneous read+write is illegal: answer straight away with a fault
                        if (d_rd && d_wr) begin
                            op_q       <= OP_IDLE;
                            rsp_data_q <= 32'd0;
                            rsp_miss_q <= 1'b0;
                            rsp_seg_q  <= 1'b1;
                            state_q    <= S_RESP;
                        end else begin
                            op_q    <= d_wr ? OP_WRITE : OP_READ;
                            state_q <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (m_ack) begin
                        rsp_data_q <= (op_q == OP_WRITE) ? 32'd0 : m_rd_data;
                        rsp_miss_q <= m_miss;
                        rsp_seg_q  <= m_segfault;
                        state_q    <= S_RESP;
                    end else if (to_cnt_q == TO_LAST) begin
                        rsp_data_q <= 32'd0;
                        rsp_miss_q <= 1'b0;
                        rsp_seg_q  <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_req_arbiter.sv
// Directed bench for mmu_req_arbiter: fetch path, starvation, timeout, illegal rd+wr, mid-op reset.
module tb_mmu_req_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic [2:0]  i_trd;
    logic        i_gnt;
    logic        i_valid;
    logic [31:0] i_rd_data;
    logic        i_miss;
    logic        i_segfault;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wr_data;
    logic [2:0]  d_trd;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rd_data;
    logic        d_miss;
    logic        d_segfault;
    logic [1:0]  m_opcode;
    logic [31:0] m_addr;
    logic [31:0] m_wr_data;
    logic [2:0]  m_trd;
    logic        m_ack;
    logic [31:0] m_rd_data;
    logic        m_miss;
    logic        m_segfault;

    int checks;
    int failures;

    mmu_req_arbiter #(.ST_LIMIT(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_trd(i_trd), .i_gnt(i_gnt),
        .i_valid(i_valid), .i_rd_data(i_rd_data), .i_miss(i_miss), .i_segfault(i_segfault),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wr_data(d_wr_data), .d_trd(d_trd),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rd_data(d_rd_data), .d_miss(d_miss),
        .d_segfault(d_segfault),
        .m_opcode(m_opcode), .m_addr(m_addr), .m_wr_data(m_wr_data), .m_trd(m_trd),
        .m_ack(m_ack), .m_rd_data(m_rd_data), .m_miss(m_miss), .m_segfault(m_segfault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        i_req = 0; i_addr = 0; i_trd = 0;
        d_rd = 0; d_wr = 0; d_addr = 0; d_wr_data = 0; d_trd = 0;
        m_ack = 0; m_rd_data = 0; m_miss = 0; m_segfault = 0;
        #3;
        chk("rst_opcode", 32'(m_opcode), 32'd0);
        chk("rst_maddr", m_addr, 32'd0);
        chk("rst_valid", {30'd0, i_valid, d_valid}, 32'd0);
        chk("rst_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Fetch: grant cycle 0, READ cycles 1-2, ack in cycle 2, i_valid cycle 3
        i_req = 1; i_addr = 32'h100; i_trd = 3'd3;
        #1 chk("f_igrant", {30'd0, i_gnt, d_gnt}, 32'b10);
        chk("f_op_c0", 32'(m_opcode), 32'd0);
        step(); i_req = 0;
        #1 chk("f_op_c1", 32'(m_opcode), 32'd1);
        chk("f_addr", m_addr, 32'h100);
        chk("f_trd", 32'(m_trd), 32'd3);
        chk("f_novalid_c1", 32'(i_valid), 32'd0);
        step(); m_ack = 1; m_rd_data = 32'hDEADBEEF;
        #1 chk("f_op_c2", 32'(m_opcode), 32'd1);
        step(); m_ack = 0; m_rd_data = 0;
        #1 chk("f_ivalid", {30'd0, i_valid, d_valid}, 32'b10);
        chk("f_data", i_rd_data, 32'hDEADBEEF);
        chk("f_flags", {30'd0, i_miss, i_segfault}, 32'd0);
        chk("f_op_c3", 32'(m_opcode), 32'd0);
        step();
        #1 chk("f_idle_valid", 32'(i_valid), 32'd0);
        chk("f_idle_data", i_rd_data, 32'd0);

        // D read with miss, ack in first BUSY cycle
        d_rd = 1; d_addr = 32'h2A0; d_trd = 3'd2;
        #1 chk("dr_gnt", {30'd0, i_gnt, d_gnt}, 32'b01);
        step(); d_rd = 0; m_ack = 1; m_rd_data = 32'h0BAD_F00D; m_miss = 1;
        #1 chk("dr_op", 32'(m_opcode), 32'd1);
        step(); m_ack = 0; m_rd_data = 0; m_miss = 0;
        #1 chk("dr_valid", {30'd0, i_valid, d_valid}, 32'b01);
        chk("dr_data", d_rd_data, 32'h0BAD_F00D);
        chk("dr_flags", {30'd0, d_miss, d_segfault}, 32'b10);
        step();

        // Starvation: d_wr and i_req held, ack held high (ignored outside BUSY)
        d_wr = 1; d_addr = 32'h500; d_wr_data = 32'hA5A5_0001; d_trd = 3'd1;
        i_req = 1; i_addr = 32'h700; i_trd = 3'd4;
        m_ack = 1; m_rd_data = 32'h1234_5678;
        for (int g = 0; g < 6; g++) begin
            #1 chk($sformatf("st_gnt%0d", g), {30'd0, i_gnt, d_gnt}, (g == 4) ? 32'b10 : 32'b01);
            step();
            #1 chk($sformatf("st_op%0d", g), 32'(m_opcode), (g == 4) ? 32'd1 : 32'd3);
            chk($sformatf("st_addr%0d", g), m_addr, (g == 4) ? 32'h700 : 32'h500);
            chk($sformatf("st_busy_gnt%0d", g), {30'd0, i_gnt, d_gnt}, 32'd0);
            step();
            #1 chk($sformatf("st_valid%0d", g), {30'd0, i_valid, d_valid}, (g == 4) ? 32'b10 : 32'b01);
            chk($sformatf("st_data%0d", g), (g == 4) ? i_rd_data : d_rd_data, (g == 4) ? 32'h1234_5678 : 32'd0);
            chk($sformatf("st_resp_gnt%0d", g), {30'd0, i_gnt, d_gnt}, 32'd0);
            step();
        end
        d_wr = 0; i_req = 0; m_ack = 0; m_rd_data = 0;
        step(); step(); step();

        // Timeout: d_rd, no ack, eight BUSY cycles then faulted response
        d_rd = 1; d_addr = 32'h800; d_trd = 3'd7;
        m_rd_data = 32'hFFFF_FFFF; m_miss = 1;
        #1 chk("to_gnt", 32'(d_gnt), 32'd1);
        for (int c = 1; c <= 8; c++) begin
            step(); d_rd = 0;
            #1 chk($sformatf("to_busy%0d", c), 32'(m_opcode), 32'd1);
            chk($sformatf("to_novalid%0d", c), 32'(d_valid), 32'd0);
        end
        step();
        #1 chk("to_valid", 32'(d_valid), 32'd1);
        chk("to_flags", {30'd0, d_miss, d_segfault}, 32'b01);
        chk("to_data", d_rd_data, 32'd0);
        chk("to_op", 32'(m_opcode), 32'd0);
        m_rd_data = 0; m_miss = 0;
        step();

        // Illegal simultaneous read+write
        d_rd = 1; d_wr = 1; d_addr = 32'h900;
        #1 chk("rw_gnt", 32'(d_gnt), 32'd1);
        step(); d_rd = 0; d_wr = 0;
        #1 chk("rw_op", 32'(m_opcode), 32'd0);
        chk("rw_valid", 32'(d_valid), 32'd1);
        chk("rw_seg", {30'd0, d_miss, d_segfault}, 32'b01);
        chk("rw_data", d_rd_data, 32'd0);
        step();
        #1 chk("rw_after", 32'(d_valid), 32'd0);

        // Reset in the middle of BUSY
        i_req = 1; i_addr = 32'h300; i_trd = 3'd5;
        #1 chk("rb_gnt", 32'(i_gnt), 32'd1);
        step(); i_req = 0;
        #1 chk("rb_busy", 32'(m_opcode), 32'd1);
        #2 rst_n = 1'b0; m_ack = 1; m_rd_data = 32'h5555_AAAA;
        #1 chk("rb_op_now", 32'(m_opcode), 32'd0);
        chk("rb_addr_now", m_addr, 32'd0);
        step();
        #1 chk("rb_novalid", {30'd0, i_valid, d_valid}, 32'd0);
        step();
        rst_n = 1'b1; m_ack = 0; m_rd_data = 0;
        i_req = 1; i_addr = 32'h400; i_trd = 3'd6;
        #1 chk("ra_gnt", 32'(i_gnt), 32'd1);
        chk("ra_novalid", {30'd0, i_valid, d_valid}, 32'd0);
        step(); i_req = 0;
        #1 chk("ra_addr", m_addr, 32'h400);
        chk("ra_trd", 32'(m_trd), 32'd6);
        m_ack = 1; m_rd_data = 32'hCAFE_F00D;
        step(); m_ack = 0; m_rd_data = 0;
        #1 chk("ra_valid", 32'(i_valid), 32'd1);
        chk("ra_data", i_rd_data, 32'hCAFE_F00D);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
